// File: rtl/mips_bus_arbiter_if.sv
// rtl/mips_bus_arbiter_if.sv - requester and Avalon master signal bundle for mips_bus_arbiter
interface mips_bus_arbiter_if #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  localparam int BE_W = DATA_W / 8;

  // requester side
  logic [N_PORTS-1:0]        req_valid;
  logic [N_PORTS-1:0]        req_ready;
  logic [N_PORTS-1:0]        req_write;
  logic [N_PORTS*ADDR_W-1:0] req_addr;
  logic [N_PORTS*DATA_W-1:0] req_wdata;
  logic [N_PORTS*BE_W-1:0]   req_be;
  logic [N_PORTS-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      busy;

  // Avalon master side
  logic [ADDR_W-1:0]         address;
  logic                      write;
  logic                      read;
  logic [DATA_W-1:0]         writedata;
  logic [BE_W-1:0]           byteenable;
  logic                      waitrequest;
  logic [DATA_W-1:0]         readdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_be, waitrequest, readdata,
    output req_ready, rsp_valid, rsp_rdata, busy,
    output address, write, read, writedata, byteenable
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_be, waitrequest, readdata,
    input  req_ready, rsp_valid, rsp_rdata, busy,
    input  address, write, read, writedata, byteenable
  );
endinterface

// File: rtl/mips_bus_arbiter.sv
// rtl/mips_bus_arbiter.sv - N-port arbiter driving one non-pipelined Avalon master
module mips_bus_arbiter #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RR      = 1
) (
  input logic             clk,
  input logic             reset,
  mips_bus_arbiter_if.master bus
);
  localparam int BE_W = DATA_W / 8;
  localparam int GW   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic {IDLE, BUS} state_t;

  state_t               state, state_nxt;
  logic [GW-1:0]        last_grant, grant, cur_port;
  logic [GW:0]          start;
  logic [2*N_PORTS-1:0] rotated;
  logic                 any_req, accept, done;
  logic [N_PORTS-1:0]   ready, rsp_pulse;
  logic                 rd_q, wr_q, busy_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q, rdata_q;
  logic [BE_W-1:0]      be_q;

  assign done = (rd_q | wr_q) & ~bus.waitrequest;

  // Pick the winner: rotate the request vector so the search starts at the preferred port.
  always_comb begin : arbitrate
    logic [GW:0] idx;
    idx     = '0;
    start   = (RR != 0) ? ({1'b0, last_grant} + (GW+1)'(1)) : '0;
    rotated = {bus.req_valid, bus.req_valid} >> start;
    any_req = 1'b0;
    grant   = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (!any_req && rotated[k]) begin
        idx = start + (GW+1)'(k);
        if (idx >= (GW+1)'(N_PORTS)) idx = idx - (GW+1)'(N_PORTS);
        any_req = 1'b1;
        grant   = idx[GW-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and combinational accept; ready is masked while reset is held.
  always_comb begin
    state_nxt = state;
    ready     = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req && reset) begin
          accept       = 1'b1;
          ready[grant] = 1'b1;
          state_nxt    = BUS;
        end
      end
      BUS: begin
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the granted request into the bus registers; retire it on the completing edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= GW'(N_PORTS - 1);
      cur_port   <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rdata_q    <= '0;
      rsp_pulse  <= '0;
    end else begin
      rsp_pulse <= '0;
      if (accept) begin
        cur_port   <= grant;
        last_grant <= grant;
        addr_q     <= bus.req_addr[grant*ADDR_W +: ADDR_W];
        wdata_q    <= bus.req_wdata[grant*DATA_W +: DATA_W];
        be_q       <= bus.req_be[grant*BE_W +: BE_W];
        wr_q       <= bus.req_write[grant];
        rd_q       <= ~bus.req_write[grant];
        busy_q     <= 1'b1;
      end else if (state == BUS && done) begin
        rd_q                <= 1'b0;
        wr_q                <= 1'b0;
        busy_q              <= 1'b0;
        rsp_pulse[cur_port] <= 1'b1;
        if (rd_q) rdata_q <= bus.readdata;
      end
    end
  end

  assign bus.req_ready  = ready;
  assign bus.rsp_valid  = rsp_pulse;
  assign bus.rsp_rdata  = rdata_q;
  assign bus.busy       = busy_q;
  assign bus.address    = addr_q;
  assign bus.write      = wr_q;
  assign bus.read       = rd_q;
  assign bus.writedata  = wdata_q;
  assign bus.byteenable = be_q;
endmodule
